// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
//
// Sequential BCD-to-binary converter. Takes an 11-digit unsigned BCD number
// and produces its 36-bit binary value using reverse double-dabble: each
// clock the {bcd, bin} working register shifts right by one bit, then every
// BCD digit that reads 8 or more has 3 subtracted from it. After 36 shifts
// the bin half holds value mod 2^36 and the bcd half holds value / 2^36.
//
// Ports:
//   Clk          in   1   rising-edge clock
//   Reset        in   1   synchronous, active-high; overrides all inputs
//   start        in   1   conversion request, only honoured in IDLE
//   BCD0..BCD10  in   4   decimal digits, BCD0 least significant,
//                         sampled only on the accepted start edge
//   data         out  36  binary result, held until next result or Reset
//   busy         out  1   high while shifting
//   done         out  1   one-cycle pulse when data/ovf/err are valid
//   ovf          out  1   value exceeded 2^36-1, held until next start
//   err          out  1   a digit was above 9, held until next start
//
// Build option:
//   BCD2BIN_SATURATE_EN  when defined, an overflowing result drives data to
//                        all ones; otherwise data is the value mod 2^36.
// ---------------------------------------------------------------------------
module bcd_to_binary_seq (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [3:0]  BCD0,
   input  logic [3:0]  BCD1,
   input  logic [3:0]  BCD2,
   input  logic [3:0]  BCD3,
   input  logic [3:0]  BCD4,
   input  logic [3:0]  BCD5,
   input  logic [3:0]  BCD6,
   input  logic [3:0]  BCD7,
   input  logic [3:0]  BCD8,
   input  logic [3:0]  BCD9,
   input  logic [3:0]  BCD10,
   output logic [35:0] data,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [43:0] bcd_in;
   logic        digit_bad;
   logic [79:0] work;
   logic [79:0] shifted;
   logic [79:0] adjusted;
   logic [5:0]  count;
   logic        bad_pending;
   logic        remainder_nz;

   assign bcd_in = {BCD10, BCD9, BCD8, BCD7, BCD6, BCD5,
                    BCD4,  BCD3, BCD2, BCD1, BCD0};

   assign busy         = (state == SHIFT);
   assign remainder_nz = |work[79:36];

   // Flags any input digit outside 0..9 so the conversion can be skipped.
   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            digit_bad = 1'b1;
         end
      end
   end

   // One reverse double-dabble step. A digit is 8 or more exactly when its
   // top bit is set, so that bit alone selects the minus-3 correction.
   always_comb begin
      shifted  = {1'b0, work[79:1]};
      adjusted = shifted;
      for (int i = 0; i < 11; i++) begin
         if (shifted[36 + 4*i + 3]) begin
            adjusted[36 + 4*i +: 4] = shifted[36 + 4*i +: 4] - 4'd3;
         end
      end
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A bad digit skips shifting and goes straight to
   // FINISH so the error is reported one cycle after the start edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = digit_bad ? FINISH : SHIFT;
            end
         end
         SHIFT: begin
            if (count == 6'd35) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and result registers. done is registered on the FINISH to
   // IDLE edge, so it is high during the first IDLE cycle afterwards.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         work        <= '0;
         count       <= '0;
         bad_pending <= 1'b0;
         data        <= '0;
         done        <= 1'b0;
         ovf         <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ovf         <= 1'b0;
                  err         <= 1'b0;
                  bad_pending <= digit_bad;
                  count       <= '0;
                  work        <= digit_bad ? 80'd0 : {bcd_in, 36'd0};
               end
            end
            SHIFT: begin
               work  <= adjusted;
               count <= count + 6'd1;
            end
            FINISH: begin
               done <= 1'b1;
               if (bad_pending) begin
                  err  <= 1'b1;
                  ovf  <= 1'b0;
                  data <= '0;
               end else begin
                  ovf <= remainder_nz;
`ifdef BCD2BIN_SATURATE_EN
                  data <= remainder_nz ? 36'hFFFFFFFFF : work[35:0];
`else
                  data <= work[35:0];
`endif
               end
            end
            default: begin
               work <= '0;
            end
         endcase
      end
   end

endmodule
